// File: rtl/cluster_count_monitor.sv
// Purpose: integrates per-cycle cluster counts over 2^WINDOW_LOG2 valid samples into per-window sum/peak plus an overflow tally.
// Latency: sum_o/peak_o/window_done_o update one cycle after the final sample of a window.
// Backpressure: none; samples outside RUN are dropped. Define CLUSTER_MON_OVF_COUNTER_EN to build the overflow counter.
module cluster_count_monitor #(
  parameter int WINDOW_LOG2 = 12
) (
  input  logic                     clock4x,
  input  logic                     reset_n,
  input  logic [10:0]              cnt_i,
  input  logic                     overflow_i,
  input  logic                     valid_i,
  input  logic                     enable_i,
  input  logic                     snap_i,
  input  logic                     clear_i,
  output logic [11+WINDOW_LOG2-1:0] sum_o,
  output logic [10:0]              peak_o,
  output logic [15:0]              ovf_cnt_o,
  output logic                     window_done_o,
  output logic [1:0]               state_o
);

  localparam int SW = 11 + WINDOW_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                 r_state;
  logic [WINDOW_LOG2-1:0] r_smp_cnt;
  logic [SW-1:0]          r_sum_acc;
  logic [SW-1:0]          r_sum;
  logic [10:0]            r_peak_acc;
  logic [10:0]            r_peak;
  logic                   r_done;

  logic                   w_run_smp;
  logic                   w_last;
  logic                   w_acc_zero;
  logic [SW-1:0]          w_sum_next;
  logic [10:0]            w_peak_next;

  // A sample only counts while running; the window closes on the sample that fills the counter.
  assign w_run_smp   = (r_state == ST_RUN) && valid_i;
  assign w_last      = w_run_smp && (r_smp_cnt == {WINDOW_LOG2{1'b1}});
  assign w_sum_next  = r_sum_acc + SW'(cnt_i);
  assign w_peak_next = (cnt_i > r_peak_acc) ? cnt_i : r_peak_acc;

  // Accumulators are dropped when parked in IDLE, when leaving for IDLE (partial window
  // discarded) and on resume from HOLD, so every RUN window starts fresh.
  assign w_acc_zero = !enable_i || (r_state == ST_IDLE) || (r_state == ST_HOLD && snap_i) ||
                      (r_state != ST_RUN && r_state != ST_HOLD);

  // FSM plus window datapath; clear beats completion, completion beats discard.
  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_smp_cnt  <= '0;
      r_sum_acc  <= '0;
      r_sum      <= '0;
      r_peak_acc <= '0;
      r_peak     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // Disable takes precedence over snap in both active states.
      case (r_state)
        ST_IDLE: if (enable_i) r_state <= ST_RUN;
        ST_RUN: begin
          if (!enable_i)   r_state <= ST_IDLE;
          else if (snap_i) r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!enable_i)   r_state <= ST_IDLE;
          else if (snap_i) r_state <= ST_RUN;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (clear_i) begin
        r_sum      <= '0;
        r_peak     <= '0;
        r_sum_acc  <= '0;
        r_peak_acc <= '0;
        r_smp_cnt  <= '0;
      end else if (w_last) begin
        r_sum      <= w_sum_next;
        r_peak     <= w_peak_next;
        r_done     <= 1'b1;
        r_sum_acc  <= '0;
        r_peak_acc <= '0;
        r_smp_cnt  <= '0;
      end else if (w_acc_zero) begin
        r_sum_acc  <= '0;
        r_peak_acc <= '0;
        r_smp_cnt  <= '0;
      end else if (w_run_smp) begin
        r_sum_acc  <= w_sum_next;
        r_peak_acc <= w_peak_next;
        r_smp_cnt  <= r_smp_cnt + 1'b1;
      end
    end
  end

`ifdef CLUSTER_MON_OVF_COUNTER_EN
  logic [15:0] r_ovf_cnt;

  // Tally overflowed samples taken while running; sticks at all-ones instead of wrapping.
  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf_cnt <= '0;
    end else if (clear_i) begin
      r_ovf_cnt <= '0;
    end else if (w_run_smp && overflow_i && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign ovf_cnt_o = r_ovf_cnt;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = overflow_i;
  assign ovf_cnt_o    = 16'd0;
`endif

  assign sum_o         = r_sum;
  assign peak_o        = r_peak;
  assign window_done_o = r_done;
  assign state_o       = r_state;

endmodule
